// File: rtl/embarcacao_posicao_decoder.sv
// rtl/embarcacao_posicao_decoder.sv - ship position vector to occupancy map decoder
//
// Decodes a packed vector of up to eight 4+4 bit (X,Y) ship segments into a
// GRID_W x GRID_H occupancy bitmap. Decoding runs into a private shadow map,
// one segment per clock, and the finished map is published to ocupacao in a
// single edge so observers never see a half-built board.
//
// Ports:
//   clock               in   single rising-edge clock
//   reset_n             in   asynchronous active-low reset
//   load                in   start a decode (only honoured while idle)
//   posicoes_embarcacao in   64-bit packed segments, seg k: X=[8k+3:8k], Y=[8k+7:8k+4]
//   tamanho             in   number of valid segments (legal 1..MAX_SEG)
//   busy                out  decoder is not idle
//   done                out  one-cycle pulse when the new map is published
//   erro                out  sticky error of the last decode
//   ocupacao            out  published map, bit Y*GRID_W+X
//   query_x, query_y    in   cell lookup coordinates
//   hit                 out  registered lookup of the published map

module embarcacao_posicao_decoder #(
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 10,
    parameter int MAX_SEG = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [63:0]                posicoes_embarcacao,
    input  logic [3:0]                 tamanho,
    output logic                       busy,
    output logic                       done,
    output logic                       erro,
    output logic [GRID_W*GRID_H-1:0]   ocupacao,
    input  logic [3:0]                 query_x,
    input  logic [3:0]                 query_y,
    output logic                       hit
);

    localparam int CELLS = GRID_W * GRID_H;
    // The vector is fixed at 64 bits, so it never holds more than 8 segments.
    localparam int NSEG  = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pos_q, pos_d;
    logic [3:0]         tam_q, tam_d;
    logic [3:0]         idx_q, idx_d;
    logic [CELLS-1:0]   shadow_q, shadow_d;
    logic [CELLS-1:0]   ocup_q, ocup_d;
    logic               erro_q, erro_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;

    // Current segment selected by the scan index.
    logic [7:0]         seg;
    logic [3:0]         seg_x;
    logic [3:0]         seg_y;
    logic               seg_in_range;
    logic [15:0]        seg_cell;
    logic               last_seg;
    logic               tam_legal;

    // Lookup path.
    logic               q_in_range;
    logic [15:0]        q_cell;

    always_comb begin
        seg = 8'h00;
        for (int k = 0; k < NSEG; k++) begin
            if (idx_q == 4'(k)) begin
                seg = pos_q[8*k +: 8];
            end
        end
    end

    assign seg_x        = seg[3:0];
    assign seg_y        = seg[7:4];
    assign seg_in_range = (32'(seg_x) < GRID_W) && (32'(seg_y) < GRID_H);
    assign seg_cell     = 16'(seg_y) * 16'(GRID_W) + 16'(seg_x);
    assign last_seg     = (idx_q == (tam_q - 4'd1));
    assign tam_legal    = (tam_q != 4'd0) && (32'(tam_q) <= MAX_SEG);

    assign q_in_range   = (32'(query_x) < GRID_W) && (32'(query_y) < GRID_H);
    assign q_cell       = 16'(query_y) * 16'(GRID_W) + 16'(query_x);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tam_d    = tam_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        ocup_d   = ocup_q;
        erro_d   = erro_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    pos_d   = posicoes_embarcacao;
                    tam_d   = tamanho;
                    erro_d  = 1'b0;
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                shadow_d = '0;
                idx_d    = 4'd0;
                if (tam_legal) begin
                    state_d = SCAN;
                end else begin
                    erro_d  = 1'b1;
                    state_d = FINISH;
                end
            end

            SCAN: begin
                // Off-board segments flag the error but never touch the map;
                // duplicates simply OR into an already-set bit.
                if (seg_in_range) begin
                    for (int c = 0; c < CELLS; c++) begin
                        if (seg_cell == 16'(c)) begin
                            shadow_d[c] = 1'b1;
                        end
                    end
                end else begin
                    erro_d = 1'b1;
                end

                if (last_seg) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            FINISH: begin
                // Single-edge publish: ocupacao and done change together.
                ocup_d  = shadow_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lookup reads only the published map, so queries never see a decode
    // in progress.
    always_comb begin
        hit_d = 1'b0;
        if (q_in_range) begin
            for (int c = 0; c < CELLS; c++) begin
                if (q_cell == 16'(c)) begin
                    hit_d = ocup_q[c];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            tam_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            ocup_q   <= '0;
            erro_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            tam_q    <= tam_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ocup_q   <= ocup_d;
            erro_q   <= erro_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign erro     = erro_q;
    assign ocupacao = ocup_q;
    assign hit      = hit_q;

endmodule

// File: tb/tb_embarcacao_posicao_decoder.sv
// tb/tb_embarcacao_posicao_decoder.sv - scoreboard bench for embarcacao_posicao_decoder

module tb_embarcacao_posicao_decoder;

    localparam int GW = 10;
    localparam int GH = 10;
    localparam int NC = GW * GH;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [63:0]   pos = '0;
    logic [3:0]    tam = '0;
    logic [3:0]    qx = '0;
    logic [3:0]    qy = '0;
    logic          busy;
    logic          done;
    logic          erro;
    logic [NC-1:0] ocup;
    logic          hit;

    embarcacao_posicao_decoder dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .load                (load),
        .posicoes_embarcacao (pos),
        .tamanho             (tam),
        .busy                (busy),
        .done                (done),
        .erro                (erro),
        .ocupacao            (ocup),
        .query_x             (qx),
        .query_y             (qy),
        .hit                 (hit)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [NC-1:0] map;
        logic          err;
        int            edge_n;
    } exp_t;

    typedef struct {
        logic h;
        int   edge_n;
    } hexp_t;

    exp_t          exp_q[$];
    hexp_t         hit_q[$];
    logic [NC-1:0] pub_map = '0;

    // Reference: board built straight from the segment rules.
    function automatic void model(input logic [63:0] v, input int n,
                                  output logic [NC-1:0] m, output logic e);
        int x, y;
        m = '0;
        e = 1'b0;
        if (n < 1 || n > 8) begin
            e = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            x = int'(v[8*k +: 4]);
            y = int'(v[8*k+4 +: 4]);
            if (x >= GW || y >= GH) e = 1'b1;
            else m[y*GW + x] = 1'b1;
        end
    endfunction

    // Monitor: pops expectations when the DUT publishes or when a lookup lands.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            hit_q.delete();
            pub_map = '0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_map", ocup, e.map);
                    chk("done_erro", erro, e.err);
                    chk("done_latency", cyc, e.edge_n);
                    pub_map = e.map;
                end
            end
            chk("published_map", ocup, pub_map);
            if (hit_q.size() != 0 && hit_q[0].edge_n == cyc) begin
                hexp_t h;
                h = hit_q.pop_front();
                chk("hit", hit, h.h);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_load(input logic [63:0] v, input logic [3:0] n);
        exp_t          e;
        logic [NC-1:0] m;
        logic          er;
        model(v, int'(n), m, er);
        pos  = v;
        tam  = n;
        load = 1'b1;
        e.map    = m;
        e.err    = er;
        e.edge_n = cyc + 1 + ((n >= 1 && n <= 8) ? int'(n) + 2 : 2);
        exp_q.push_back(e);
        tick();
        load = 1'b0;
        pos  = {$urandom, $urandom};
        tam  = 4'($urandom);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) tick();
        chk("drain_timeout", (exp_q.size() != 0 || busy), 1'b0);
    endtask

    task automatic query(input int x, input int y);
        hexp_t h;
        qx = 4'(x);
        qy = 4'(y);
        h.h = 1'b0;
        if (x < GW && y < GH) h.h = pub_map[y*GW + x];
        h.edge_n = cyc + 1;
        hit_q.push_back(h);
        tick();
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 30 && !done; i++) tick();
        chk(name, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] m30;
        logic [63:0]   v;
        logic [3:0]    n;

        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_erro", erro, 1'b0);
        chk("reset_hit", hit, 1'b0);
        chk("reset_map", ocup, '0);
        reset_n = 1'b1;
        tick();

        // Three segments on row 2.
        start_load(64'h0000_0000_0023_2221, 4'd3);
        drain();
        m30 = '0;
        m30[21] = 1'b1;
        m30[22] = 1'b1;
        m30[23] = 1'b1;
        chk("vec3_map", ocup, m30);
        chk("vec3_erro", erro, 1'b0);

        // Single segment and lookups on/next to/off the board.
        start_load(64'h22, 4'd1);
        drain();
        query(2, 2);
        query(3, 2);
        query(12, 2);
        tick();

        // Off-board segment.
        start_load(64'h0000_0000_0000_2A22, 4'd2);
        drain();
        chk("offboard_erro", erro, 1'b1);

        // Illegal lengths.
        start_load(64'h0000_0000_0023_2221, 4'd0);
        drain();
        start_load(64'h0000_0000_0023_2221, 4'd9);
        drain();
        chk("len9_map", ocup, '0);

        // Load while busy is ignored.
        start_load(64'h0000_0000_5544_3311, 4'd4);
        pos  = 64'h0000_0000_0000_0099;
        tam  = 4'd1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("busy_during_decode", busy, 1'b1);
        load = 1'b1;
        tick();
        load = 1'b0;
        drain();

        // Back-to-back: second load in the done cycle.
        start_load(64'h0000_0000_0000_7766, 4'd2);
        wait_done("b2b_first_done");
        start_load(64'h0000_0000_0088_0011, 4'd3);
        drain();
        query(6, 6);
        query(1, 1);
        tick();

        // Reset in the middle of a scan.
        start_load(64'h9988_7766_5544_3322, 4'd8);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_erro", erro, 1'b0);
        chk("midreset_hit", hit, 1'b0);
        chk("midreset_map", ocup, '0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        start_load(64'h0000_0000_0000_0045, 4'd1);
        drain();
        query(5, 4);

        // Randomized decodes, some back-to-back.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 8; k++) begin
                v[8*k +: 4]   = 4'($urandom_range(0, 11));
                v[8*k+4 +: 4] = 4'($urandom_range(0, 11));
            end
            n = 4'($urandom_range(0, 10));
            start_load(v, n);
            if ($urandom_range(0, 2) == 0) begin
                wait_done("rand_b2b_done");
                v = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
                start_load(v, 4'($urandom_range(1, 8)));
            end
            drain();
            query(int'(v[3:0]), int'(v[7:4]));
            query($urandom_range(0, 11), $urandom_range(0, 11));
            query($urandom_range(0, 15), $urandom_range(0, 15));
        end

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size() + hit_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/embarcacao_posicao_decoder.md
EMBARCACAO_POSICAO_DECODER -- requirements
Module: embarcacao_posicao_decoder

Interface
REQ-001 SHALL have parameter GRID_W, default 10, board columns (valid X 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 10, board rows (valid Y 0..GRID_H-1).
REQ-003 SHALL have parameter MAX_SEG, default 8, maximum ship segments per vector (64/8).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  request to decode the current position vector; sampled only in IDLE.
REQ-007 posicoes_embarcacao  input  64  packed segment coordinates; segment k: X = bits [8k+3:8k], Y = bits [8k+7:8k+4].
REQ-008 tamanho  input  4  number of valid segments (legal 1..MAX_SEG), latched with load.
REQ-009 busy  output  1  high while not in IDLE.
REQ-010 done  output  1  one-cycle pulse when a decode completes.
REQ-011 erro  output  1  sticky error flag for the last decode; cleared when the next load is accepted.
REQ-012 ocupacao  output  GRID_W*GRID_H  occupancy map; bit Y*GRID_W+X high = cell holds a ship segment.
REQ-013 query_x, query_y  input  4 each  pixel-side cell lookup coordinates.
REQ-014 hit  output  1  registered lookup result for (query_x, query_y).

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, SCAN and FINISH.
REQ-016 IDLE -> CLEAR SHALL occur on a clock edge with load=1; the same edge SHALL latch posicoes_embarcacao and tamanho and clear erro.
REQ-017 load SHALL be ignored in CLEAR, SCAN and FINISH; the latched vector SHALL NOT change mid-decode.
REQ-018 CLEAR SHALL zero an internal shadow map in one cycle and then go to SCAN, or to FINISH if the latched tamanho is 0 or >MAX_SEG (erro set).
REQ-019 SCAN SHALL process one segment per cycle, index k = 0..tamanho-1, and set shadow bit Y*GRID_W+X.
REQ-020 A segment with X>=GRID_W or Y>=GRID_H SHALL set erro and SHALL NOT write the shadow map; scanning continues.
REQ-021 Duplicate coordinates SHALL be OR-ed (no error).
REQ-022 After segment tamanho-1, SCAN SHALL go to FINISH; segments >= tamanho SHALL be ignored regardless of content.
REQ-023 FINISH SHALL copy the shadow map to ocupacao, pulse done for exactly one cycle and return to IDLE; ocupacao SHALL change only on this edge (atomic update).
REQ-024 Latency: with load sampled at edge 0 and legal tamanho N, done SHALL be high in the cycle after edge N+2; for an illegal tamanho it SHALL be high after edge 2.
REQ-025 load=1 on the cycle done is high SHALL be accepted (IDLE is entered on that edge; the back-to-back load is sampled on the next edge).
REQ-026 hit SHALL equal ocupacao[query_y*GRID_W+query_x] registered with one-cycle latency; it SHALL be 0 when query_x>=GRID_W or query_y>=GRID_H.
REQ-027 hit SHALL reflect the currently published ocupacao, never the shadow map.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, and set busy=0, done=0, erro=0, hit=0, ocupacao=0 and the shadow map to 0.
REQ-029 Reset asserted mid-decode SHALL abort it with no done pulse; the first load after release SHALL start a fresh decode.

Verification
REQ-030 Vector 0x0000_0000_0023_2221, tamanho=3, load pulse -> done 5 cycles later; ocupacao bits 21,22,23 set, all others 0; erro=0.
REQ-031 Vector 0x22, tamanho=1; then query (2,2) -> hit=1 one cycle later; query (3,2) -> hit=0; query (12,2) -> hit=0.
REQ-032 Vector 0x0000_0000_0000_2A22, tamanho=2 -> erro=1, only bit 22 set, done 4 cycles after load.
REQ-033 tamanho=0 and tamanho=9 -> erro=1, ocupacao all 0, done 2 cycles after load.
REQ-034 Second load pulsed while busy -> ignored; a load in the done cycle -> second decode starts on the following edge; ocupacao holds the old map until the new FINISH.
REQ-035 reset_n pulled low during SCAN -> outputs immediately 0, no done; a later load decodes correctly.
